pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RV32 pipeline. Drives PC enable and the

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_load_use_det.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The perf counters in pipe_hazard_ctrl are enabled by PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    MDU_WAIT
  } ctrlState_t;

  // One bit per pipeline control pin driven by the output mux.
  typedef struct packed {
    logic pcStall;
    logic pcRedirect;
    logic ifidStall;
    logic ifidFlush;
    logic idexStall;
    logic idexFlush;
    logic exmemStall;
    logic memwbFlush;
  } ctrlVec_t;

endpackage

// File: rtl/pipe_load_use_det.sv
// Combinational load-use hazard compare between the ID sources and the EX load.
module pipe_load_use_det
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mem_read,
  output logic                  o_lu_hazard
);

  logic w_rs1Match;
  logic w_rs2Match;

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign w_rs1Match  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2Match  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_lu_hazard = i_ex_mem_read && (i_ex_rd != '0) && (w_rs1Match || w_rs2Match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline (Mealy controls, FSM, perf counters).
// Define PIPE_CTRL_PERF_EN to build the performance counters; otherwise perf ports read 0.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mem_read,
  input  logic                  i_ex_redirect,
  input  logic                  i_dmem_req,
  input  logic                  i_dmem_ready,
  input  logic                  i_mdu_start,
  input  logic                  i_mdu_done,
  output logic                  o_pc_stall,
  output logic                  o_pc_redirect,
  output logic                  o_ifid_stall,
  output logic                  o_ifid_flush,
  output logic                  o_idex_stall,
  output logic                  o_idex_flush,
  output logic                  o_exmem_stall,
  output logic                  o_memwb_flush,
  output logic                  o_flush_shadow,
  output logic                  o_timeout_err,
  output logic [CNT_W-1:0]      o_perf_stall,
  output logic [CNT_W-1:0]      o_perf_flush,
  output logic [CNT_W-1:0]      o_perf_lu
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  ctrlState_t        r_state;
  ctrlState_t        w_nextState;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [WAIT_W-1:0] w_nextWaitCnt;
  logic              r_flushShadow;
  logic              r_timeoutErr;
  logic              w_memFreeze;
  logic              w_mduHold;
  logic              w_timeout;
  logic              w_luHazard;
  ctrlVec_t          w_ctrl;

  pipe_load_use_det u_lu_det (
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_use_rs1  (i_id_use_rs1),
    .i_id_use_rs2  (i_id_use_rs2),
    .i_ex_rd       (i_ex_rd),
    .i_ex_mem_read (i_ex_mem_read),
    .o_lu_hazard   (w_luHazard)
  );

  // Wait counter defaults to zero so that every exit from MEM_WAIT clears it.
  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = '0;
    w_memFreeze   = 1'b0;
    w_mduHold     = 1'b0;
    w_timeout     = 1'b0;
    unique case (r_state)
      RUN: begin
        w_memFreeze = i_dmem_req && !i_dmem_ready;
        w_mduHold   = i_mdu_start && !i_mdu_done;
        if (w_memFreeze) begin
          w_nextState = MEM_WAIT;
        end else if (w_mduHold) begin
          w_nextState = MDU_WAIT;
        end
      end
      MEM_WAIT: begin
        w_memFreeze = !i_dmem_ready;
        if (i_dmem_ready) begin
          w_nextState = RUN;
        end else if (r_waitCnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_nextState = RUN;
        end else begin
          w_nextWaitCnt = r_waitCnt + 1'b1;
        end
      end
      MDU_WAIT: begin
        w_mduHold = !i_mdu_done;
        if (i_mdu_done) begin
          w_nextState = RUN;
        end
      end
      default: w_nextState = RUN;
    endcase
  end

  // Priority: memory freeze, then redirect, then MDU wait, then load-use bubble.
  always_comb begin
    w_ctrl = '0;
    if (!rst_n) begin
      w_ctrl = '0;
    end else if (w_memFreeze || (!i_ex_redirect && w_mduHold)) begin
      w_ctrl.pcStall    = 1'b1;
      w_ctrl.ifidStall  = 1'b1;
      w_ctrl.idexStall  = 1'b1;
      w_ctrl.exmemStall = 1'b1;
      w_ctrl.memwbFlush = 1'b1;
    end else if (i_ex_redirect) begin
      w_ctrl.pcRedirect = 1'b1;
      w_ctrl.ifidFlush  = 1'b1;
      w_ctrl.idexFlush  = 1'b1;
    end else if (w_luHazard) begin
      w_ctrl.pcStall   = 1'b1;
      w_ctrl.ifidStall = 1'b1;
      w_ctrl.idexFlush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_waitCnt     <= '0;
      r_flushShadow <= 1'b0;
      r_timeoutErr  <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_waitCnt     <= w_nextWaitCnt;
      r_flushShadow <= w_ctrl.ifidFlush;
      if (w_timeout) begin
        r_timeoutErr <= 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_perfStall;
  logic [CNT_W-1:0] r_perfFlush;
  logic [CNT_W-1:0] r_perfLu;
  logic             w_luBubble;

  // Only the load-use bubble stalls IF/ID without also stalling EX/MEM.
  assign w_luBubble = w_ctrl.ifidStall && !w_ctrl.exmemStall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perfStall <= '0;
      r_perfFlush <= '0;
      r_perfLu    <= '0;
    end else begin
      r_perfStall <= r_perfStall + CNT_W'(w_ctrl.pcStall);
      r_perfFlush <= r_perfFlush + CNT_W'(w_ctrl.pcRedirect);
      r_perfLu    <= r_perfLu + CNT_W'(w_luBubble);
    end
  end

  assign o_perf_stall = r_perfStall;
  assign o_perf_flush = r_perfFlush;
  assign o_perf_lu    = r_perfLu;
`else
  assign o_perf_stall = '0;
  assign o_perf_flush = '0;
  assign o_perf_lu    = '0;
`endif

  assign o_pc_stall     = w_ctrl.pcStall;
  assign o_pc_redirect  = w_ctrl.pcRedirect;
  assign o_ifid_stall   = w_ctrl.ifidStall;
  assign o_ifid_flush   = w_ctrl.ifidFlush;
  assign o_idex_stall   = w_ctrl.idexStall;
  assign o_idex_flush   = w_ctrl.idexFlush;
  assign o_exmem_stall  = w_ctrl.exmemStall;
  assign o_memwb_flush  = w_ctrl.memwbFlush;
  assign o_flush_shadow = r_flushShadow;
  assign o_timeout_err  = r_timeoutErr;

endmodule
